// File: rtl/tapped_counter_if.sv
// Control and tap bundle for tapped_counter; master drives controls, slave returns taps.
interface tapped_counter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
);
    logic                   en;
    logic                   clr;
    logic                   load;
    logic [WIDTH-1:0]       load_val;
    logic                   dir;
    logic                   sat;
    logic [WIDTH-1:0]       step;
    logic [WIDTH*DEPTH-1:0] taps;
    logic [DEPTH-1:0]       tap_vld;
    logic                   ovf;

    modport master (
        output en, clr, load, load_val, dir, sat, step,
        input  taps, tap_vld, ovf
    );

    modport slave (
        input  en, clr, load, load_val, dir, sat, step,
        output taps, tap_vld, ovf
    );
endinterface

// File: rtl/tapped_counter.sv
// Up/down wrap-or-saturate counter feeding a chain of delayed copies with per-tap valid bits.
module tapped_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input logic             clk,
    input logic             rstn,
    tapped_counter_if.slave bus
);
    localparam int unsigned TW = WIDTH * DEPTH;

    logic [TW-1:0]    taps_q;
    logic [DEPTH-1:0] vld_q;
    logic             ovf_q;

    logic [WIDTH-1:0] tap0;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] cnt_next;
    logic             ovf_next;
    logic [WIDTH-1:0] tap0_next;
    logic             ovf_d;
    logic [TW+WIDTH-1:0] taps_ext;
    logic [DEPTH:0]      vld_ext;

    assign tap0 = taps_q[WIDTH-1:0];

    always_comb begin
        sum      = {1'b0, tap0} + {1'b0, bus.step};
        cnt_next = tap0;
        ovf_next = 1'b0;
        if (bus.dir) begin
            ovf_next = sum[WIDTH];
            cnt_next = (sum[WIDTH] && bus.sat) ? '1 : sum[WIDTH-1:0];
        end else begin
            ovf_next = (bus.step > tap0);
            cnt_next = (ovf_next && bus.sat) ? '0 : tap0 - bus.step;
        end
    end

    // A load replaces the count but the chain still advances.
    always_comb begin
        tap0_next = bus.load ? bus.load_val : cnt_next;
        ovf_d     = bus.load ? 1'b0 : ovf_next;
    end

    // Concatenate-and-truncate keeps the shift legal for DEPTH=1.
    assign taps_ext = {taps_q, tap0_next};
    assign vld_ext  = {vld_q, 1'b1};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taps_q <= '0;
            vld_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.clr) begin
            taps_q <= '0;
            vld_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.en) begin
            taps_q <= taps_ext[TW-1:0];
            vld_q  <= vld_ext[DEPTH-1:0];
            ovf_q  <= ovf_d;
        end
    end

    assign bus.taps    = taps_q;
    assign bus.tap_vld = vld_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: doc/tapped_counter.md
# tapped_counter

Parametrised up/down counter with a delay-tap chain. It generalises the fixed 8-bit, three-stage counter/delay block to configurable width and depth, and adds:
- enable/stall, synchronous flush and parallel load;
- runtime direction and step;
- wrap or saturate overflow mode with an overflow flag;
- per-tap valid bits.

It serves as a stimulus/timestamp source and as a skewed-copy generator for pipeline-alignment testing.

## Interface
- WIDTH, 8, counter and tap width in bits (≥2)
- DEPTH, 3, number of taps including the counter itself (≥1); tap 0 is the counter, taps 1..DEPTH-1 are delayed copies
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  advance enable; 0 = stall (counter, taps, valids hold)
- clr  in  1  synchronous flush, not gated by en
- load  in  1  parallel load of counter, gated by en
- load_val  in  WIDTH  load value
- dir  in  1  1 = count up, 0 = count down
- sat  in  1  0 = wrap modulo 2^WIDTH, 1 = saturate at 0 / 2^WIDTH-1
- step  in  WIDTH  increment/decrement amount (unsigned)
- taps  out  WIDTH*DEPTH  tap k at bits [k*WIDTH +: WIDTH]
- tap_vld  out  DEPTH  bit k = tap k holds a value produced since reset/flush
- ovf  out  1  registered carry/borrow flag

## Operation
- Priority per rising edge: clr > (en & load) > (en & count) > hold.
- clr=1 (regardless of en):
  - all taps ← 0, tap_vld ← 0, ovf ← 0.
- en=1, load=1, clr=0:
  - tap0 ← load_val, ovf ← 0; taps shift (tap k ← tap k-1 for k≥1).
  - tap_vld ← {tap_vld[DEPTH-2:0], 1}.
- en=1, load=0, clr=0: tap0 ← next count; taps and tap_vld shift as above.
  - Up: sum = tap0 + step computed in WIDTH+1 bits; carry = sum[WIDTH].
    - carry with sat=0: tap0 ← sum[WIDTH-1:0].
    - carry with sat=1: tap0 ← all ones.
  - Down: diff = tap0 − step; borrow = (step > tap0).
    - borrow with sat=0: tap0 ← diff modulo 2^WIDTH.
    - borrow with sat=1: tap0 ← 0.
  - ovf ← carry (up) or borrow (down), in the same edge as the new tap0.
  - ovf therefore stays 1 on every enabled edge while pinned at a saturation limit with step≠0.
  - step=0: tap0 holds, ovf ← 0, taps still shift.
- en=0, clr=0:
  - Everything holds, including ovf.
  - load is ignored.
- dir, sat and step are sampled every edge; changing them mid-run takes effect on the next count edge with no side effects.
- DEPTH=1: no delay taps; tap_vld is 1 bit.

## Timing
- Reset (rstn=0): taps=0, tap_vld=0, ovf=0 immediately (asynchronous), held until rstn rises.
- First counting edge after reset: tap0 = step (up) or saturated/wrapped result (down).
- Tap latency: tap k = the tap0 value from k enabled edges earlier; stall cycles do not count.
- Load latency: load_val appears on tap0 one edge after load; on tap k after k+1 enabled edges.
- tap_vld[k] rises on the (k+1)-th enabled edge after reset/flush.
- clr latency: one edge; the following enabled edge restarts counting from 0.
- Reset mid-operation: outputs clear asynchronously regardless of en/clr/load; no partial state survives.
- All outputs are registered; there is no combinational input→output path.

## Test plan
- Count and skew (WIDTH=8, DEPTH=3): reset release; en=1, dir=1, step=1, sat=0.
  - After 5 edges: tap0=5, tap1=4, tap2=3.
  - tap_vld = 001, 011, 111 on edges 1-3.
  - ovf=0 throughout.
- Wrap: load 8'hFE, then one up edge with step=3, sat=0 → tap0=8'h01, ovf=1 for that cycle; next edge with step=1 → tap0=8'h02, ovf=0.
- Saturate:
  - Down: load 8'h02, dir=0, step=5, sat=1 → tap0=8'h00, ovf=1; stays 0 with ovf=1 on further edges.
  - Up: load 8'hFD, dir=1, step=5 → tap0=8'hFF, ovf=1.
- Stall: en=0 for 4 cycles mid-count with load=1, load_val=8'hAA → taps, tap_vld and ovf unchanged; load ignored.
- Flush priority: en=0, clr=1, load=1 with taps={7,6,5} → next edge taps=0, tap_vld=000, ovf=0; clr with en=1, load=1 → clr wins.
- Async reset: drop rstn between edges while tap0=8'h40 → all outputs 0 before the next clk edge; resume counting from 0 after release.
